// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Build option: DMEM_MISALIGN_TRAP_EN (misaligned half/word access returns rsp_err).
package dmem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RSP
    } state_t;

    // 011, 110, 111 never decode; unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3[1] & f3[0]) | (f3[2] & f3[1]) | (we & f3[2]);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return ((f3[1:0] == 2'b01) & lane[0]) | ((f3[1:0] == 2'b10) & (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane select/extend for loads and lane merge for sub-word stores.
// Build option: DMEM_MISALIGN_TRAP_EN (no effect here; unaligned lanes are aligned down).
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]        func3,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] word_in,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_ext,
    output logic [WORD_W-1:0] store_merged
);

    logic              is_byte;
    logic              is_half;
    logic              sext;
    logic [4:0]        bit_ofs;
    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    assign is_byte  = (func3[1:0] == 2'b00);
    assign is_half  = (func3[1:0] == 2'b01);
    assign sext     = ~func3[2];
    assign bit_ofs  = {lane, 3'b000};
    assign byte_sel = word_in[bit_ofs +: BYTE_W];
    assign half_sel = lane[1] ? word_in[31:16] : word_in[15:0];

    always_comb begin
        load_ext     = word_in;
        store_merged = wdata;
        unique case (1'b1)
            is_byte: begin
                load_ext = {{(WORD_W-BYTE_W){sext & byte_sel[BYTE_W-1]}}, byte_sel};
                store_merged = word_in;
                store_merged[bit_ofs +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            is_half: begin
                load_ext = {{(WORD_W-HALF_W){sext & half_sel[HALF_W-1]}}, half_sel};
                store_merged = lane[1] ? {wdata[15:0], word_in[15:0]}
                                       : {word_in[31:16], wdata[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences core loads/stores onto a word-wide, single-port data memory.
// Build option: DMEM_MISALIGN_TRAP_EN (misaligned half/word access returns rsp_err).
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic              err_q;

    logic              bad;
    logic              word_st;
    logic [31:0]       load_ext;
    logic [31:0]       store_merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad = f3_illegal(req_we, req_func3) | f3_misaligned(req_func3, req_addr[1:0]);
`else
    assign bad = f3_illegal(req_we, req_func3);
`endif

    assign word_st = req_we & (req_func3 == F3_W);

    dmem_lane_align u_align (
        .func3        (f3_q),
        .lane         (lane_q),
        .word_in      (mem_rdata),
        .wdata        (wdata_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    // Loads also pass through WR (no strobe) so every sub-word path ends at T+4.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_func3;
                        lane_q  <= req_addr[1:0];
                        waddr_q <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        err_q   <= bad;
                        data_q  <= (word_st & ~bad) ? req_wdata : 32'h0;
                        if (bad)
                            state <= RSP;
                        else if (word_st)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    data_q <= we_q ? store_merged : load_ext;
                    state  <= WR;
                end
                WR:  state <= RSP;
                RSP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = ~reset & (state == IDLE);
    assign rsp_valid = ~reset & (state == RSP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? data_q : 32'h0;
    assign mem_re    = ~reset & (state == RD);
    assign mem_we    = ~reset & (state == WR) & we_q;
    assign mem_addr  = (mem_re | mem_we) ? waddr_q : '0;
    assign mem_wdata = mem_we ? data_q : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 1-cycle-latency memory.
// Build option: DMEM_MISALIGN_TRAP_EN (changes expectations for misaligned accesses).
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int failures = 0;

    int          re_c, we_c, rsp_c;
    logic [31:0] re_a, we_a, we_d, rd;
    logic        er;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; records the cycle offset (from accept T) of each strobe.
    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_func3 = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        re_c = -1; we_c = -1; rsp_c = -1;
        re_a = '0; we_a = '0; we_d = '0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_re && re_c < 0) begin re_c = k; re_a = 32'(mem_addr); end
            if (mem_we && we_c < 0) begin
                we_c = k; we_a = 32'(mem_addr); we_d = mem_wdata;
            end
            if (rsp_valid) begin rsp_c = k; rd = rsp_rdata; er = rsp_err; break; end
        end
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        xact(1'b0, f3, a, 32'h0);
        chk({tag, "_rsp_cyc"}, 32'(rsp_c), 32'd4);
        chk({tag, "_re_cyc"}, 32'(re_c), 32'd1);
        chk({tag, "_we_cyc"}, 32'(we_c), 32'hFFFF_FFFF);
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_err"}, {31'b0, er}, 32'd0);
    endtask

    initial begin
        int bad_cnt;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'b000;
        req_addr  = '0;
        req_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_outs", {28'b0, rsp_valid, rsp_err, mem_re, mem_we}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Word store, then byte loads
        xact(1'b1, 3'b010, 32'h0, 32'h8899AABB);
        chk("sw0_we_cyc", 32'(we_c), 32'd1);
        chk("sw0_re_cyc", 32'(re_c), 32'hFFFF_FFFF);
        chk("sw0_rsp_cyc", 32'(rsp_c), 32'd2);
        chk("sw0_wdata", we_d, 32'h8899AABB);
        chk("sw0_rdata", rd, 32'd0);

        load_chk("lb1", 3'b000, 32'h1, 32'hFFFFFFAA);
        load_chk("lbu3", 3'b100, 32'h3, 32'h00000088);
        load_chk("lhu0", 3'b101, 32'h0, 32'h0000AABB);
        load_chk("lw0", 3'b010, 32'h0, 32'h8899AABB);
        load_chk("lb0", 3'b000, 32'h0, 32'hFFFFFFBB);

`ifdef DMEM_MISALIGN_TRAP_EN
        xact(1'b0, 3'b001, 32'h3, 32'h0);
        chk("lh3_rsp_cyc", 32'(rsp_c), 32'd1);
        chk("lh3_err", {31'b0, er}, 32'd1);
        chk("lh3_re_cyc", 32'(re_c), 32'hFFFF_FFFF);
        chk("lh3_rdata", rd, 32'd0);
        xact(1'b0, 3'b010, 32'h2, 32'h0);
        chk("lw2_err", {31'b0, er}, 32'd1);
        chk("lw2_rsp_cyc", 32'(rsp_c), 32'd1);
`else
        load_chk("lh3", 3'b001, 32'h3, 32'hFFFF8899);
        load_chk("lw2", 3'b010, 32'h2, 32'h8899AABB);
`endif

        // Sub-word store read-modify-write
        xact(1'b1, 3'b010, 32'h0, 32'h11223344);
        xact(1'b1, 3'b000, 32'h2, 32'h000000EE);
        chk("sb2_re_cyc", 32'(re_c), 32'd1);
        chk("sb2_we_cyc", 32'(we_c), 32'd3);
        chk("sb2_rsp_cyc", 32'(rsp_c), 32'd4);
        chk("sb2_wdata", we_d, 32'h11EE3344);
        chk("sb2_err", {31'b0, er}, 32'd0);

        xact(1'b1, 3'b001, 32'h2, 32'h1234CAFE);
        chk("sh2_we_cyc", 32'(we_c), 32'd3);
        chk("sh2_wdata", we_d, 32'hCAFE3344);

        xact(1'b1, 3'b000, 32'h1, 32'hFFFFFF77);
        chk("sb1_wdata", we_d, 32'hCAFE7744);

        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw10_re_cyc", 32'(re_c), 32'hFFFF_FFFF);
        chk("sw10_we_cyc", 32'(we_c), 32'd1);
        chk("sw10_maddr", we_a, 32'd4);
        chk("sw10_rsp_cyc", 32'(rsp_c), 32'd2);
        chk("sw10_err", {31'b0, er}, 32'd0);
        load_chk("lw10", 3'b010, 32'h10, 32'hDEADBEEF);

        // Illegal func3
        xact(1'b0, 3'b011, 32'h0, 32'h0);
        chk("ill_ld_rsp_cyc", 32'(rsp_c), 32'd1);
        chk("ill_ld_err", {31'b0, er}, 32'd1);
        chk("ill_ld_strobes", {re_c < 0, we_c < 0}, 32'd3);
        chk("ill_ld_rdata", rd, 32'd0);
        xact(1'b1, 3'b100, 32'h0, 32'h55);
        chk("ill_st_err", {31'b0, er}, 32'd1);
        chk("ill_st_we_cyc", 32'(we_c), 32'hFFFF_FFFF);

        // Reset during sub-word store at T+2
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_re", {31'b0, mem_re}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", {30'b0, mem_we, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        bad_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_we || rsp_valid) bad_cnt++;
            @(negedge clk);
        end
        chk("rst_mid_quiet", 32'(bad_cnt), 32'd0);
        load_chk("rst_mid_lw", 3'b010, 32'h0, 32'hCAFE7744);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
